// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg -- shared types and helpers for the iterative floating-point square
// root unit.
//
//   state_e   : control states of the sequencer (IDLE, NORM, ITER, ROUND, DONE)
//   class_e   : operand classification produced during normalisation
//   fp_bias   : exponent bias for a given exponent width
//   fp_qnan   : canonical quiet NaN bit pattern (sign 0, exponent all ones,
//               fraction MSB set) for a given format, LSB-aligned in 64 bits
// -----------------------------------------------------------------------------
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ITER,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_ZERO,
    C_SUBNORM,
    C_NORMAL,
    C_INF,
    C_QNAN,
    C_SNAN
  } class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc -- combinational leading-zero counter.
//
//   in_i  [WIDTH-1:0] : value to scan, MSB first
//   cnt_o [CNT_W-1:0] : number of zeros above the most significant one;
//                       WIDTH when in_i is all zeros
// -----------------------------------------------------------------------------
module fp_lzc #(
  parameter int WIDTH = 23,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic found;

  // NOTE: every signal written in an always_comb gets a value before any
  // condition; a path that leaves it unassigned would infer a latch.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_i[i]) begin
        cnt_o = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// -----------------------------------------------------------------------------
// fp_sqrt_iter -- iterative IEEE-754 square root, round-to-nearest-even.
// One operation in flight; fixed latency of MAN_W+4 cycles from accept to
// out_valid, specials included.
//
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_ready: operand handshake (in_ready only in IDLE)
//   operand_1 [W]    : {sign, exponent, fraction}
//   out_valid/out_ready : result handshake; result and flags held while stalled
//   result [W]       : square root
//   flag_invalid     : sNaN, -inf or negative non-zero operand
//   flag_inexact     : rounded result differs from the exact root
// -----------------------------------------------------------------------------
module fp_sqrt_iter
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] operand_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_invalid,
  output logic         flag_inexact
);

  // Significand of the radicand and of the root: 1 integer + MAN_W fraction
  // + 1 extra bit (radicand: odd-exponent headroom; root: guard bit).
  localparam int SIG_W = MAN_W + 2;
  localparam int RAD_W = 2 * SIG_W;
  localparam int REM_W = MAN_W + 4;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam int LZ_W  = $clog2(MAN_W + 1);
  localparam int EW    = EXP_W + LZ_W + 2;

  localparam logic signed [EW-1:0] BIAS_S   = EW'(fp_bias(EXP_W));
  localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [CNT_W-1:0]     LAST_IT  = CNT_W'(MAN_W + 1);

  state_e                 state_q, state_d;
  logic [W-1:0]           op_q, op_d;
  class_e                 cls_q, cls_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [RAD_W-1:0]       rad_q, rad_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [SIG_W-1:0]       root_q, root_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic                   inv_q, inv_d;
  logic                   inx_q, inx_d;

  // ---------------------------------------------------------------------------
  // Unpack, classify and normalise the registered operand
  // ---------------------------------------------------------------------------
  logic                 op_sign;
  logic [EXP_W-1:0]     op_exp;
  logic [MAN_W-1:0]     op_frac;
  logic [LZ_W-1:0]      frac_lz;
  class_e               op_cls;
  logic [MAN_W:0]       sig_n;
  logic signed [EW-1:0] e_n;
  logic                 e_odd;
  logic [SIG_W-1:0]     sig_even;
  logic signed [EW-1:0] e_even;

  assign op_sign = op_q[W-1];
  assign op_exp  = op_q[W-2:MAN_W];
  assign op_frac = op_q[MAN_W-1:0];

  fp_lzc #(
    .WIDTH (MAN_W),
    .CNT_W (LZ_W)
  ) u_lzc (
    .in_i  (op_frac),
    .cnt_o (frac_lz)
  );

  always_comb begin
    op_cls = C_NORMAL;
    if (op_exp == '0) begin
      op_cls = (op_frac == '0) ? C_ZERO : C_SUBNORM;
    end else if (op_exp == EXP_ONES) begin
      if (op_frac == '0)          op_cls = C_INF;
      else if (op_frac[MAN_W-1])  op_cls = C_QNAN;
      else                        op_cls = C_SNAN;
    end
  end

  always_comb begin
    if (op_exp == '0) begin
      // Shift the leading one of a subnormal fraction up into the hidden-bit
      // position; the value is then 1.f * 2^(-BIAS - lz).
      sig_n = ({1'b0, op_frac} << frac_lz) << 1;
      e_n   = -BIAS_S - EW'(frac_lz);
    end else begin
      sig_n = {1'b1, op_frac};
      e_n   = EW'(op_exp) - BIAS_S;
    end
  end

  // An odd exponent is made even by doubling the significand; clearing bit 0
  // of an odd two's-complement number is the same as subtracting one.
  assign e_odd    = e_n[0];
  assign sig_even = e_odd ? {sig_n, 1'b0} : {1'b0, sig_n};
  assign e_even   = {e_n[EW-1:1], 1'b0};

  // ---------------------------------------------------------------------------
  // One restoring root step: bring down two radicand bits, try q*4+1
  // ---------------------------------------------------------------------------
  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             take;
  logic [REM_W-1:0] rem_next;

  assign rem_sh   = {rem_q[REM_W-3:0], rad_q[RAD_W-1:RAD_W-2]};
  assign trial    = {root_q, 2'b01};
  assign take     = (rem_sh >= trial);
  assign rem_next = take ? (rem_sh - trial) : rem_sh;

  // ---------------------------------------------------------------------------
  // Rounding of the finite result
  // ---------------------------------------------------------------------------
  logic                 guard;
  logic                 sticky;
  logic                 rnd_up;
  logic [MAN_W:0]       frac_sum;
  logic                 carry;
  logic signed [EW-1:0] exp_half;
  logic [EXP_W-1:0]     res_exp;
  logic [W-1:0]         fin_result;

  assign guard    = root_q[0];
  assign sticky   = (rem_q != '0);
  assign rnd_up   = guard & (sticky | root_q[1]);
  assign frac_sum = {1'b0, root_q[MAN_W:1]} + (MAN_W + 1)'(rnd_up);
  assign carry    = frac_sum[MAN_W];
  // Kept as its own signed signal so the shift stays arithmetic.
  assign exp_half = exp_q >>> 1;
  assign res_exp  = EXP_W'(exp_half + BIAS_S + EW'(carry));
  // On carry-out the fraction bits are all zero, which is the correct 1.0.
  assign fin_result = {1'b0, res_exp, frac_sum[MAN_W-1:0]};

  // ---------------------------------------------------------------------------
  // Sequencer and datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cls_d    = cls_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    inv_d    = inv_q;
    inx_d    = inx_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = operand_1;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        cls_d   = op_cls;
        sign_d  = op_sign;
        exp_d   = e_even;
        rad_d   = {sig_even, {SIG_W{1'b0}}};
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_next;
        root_d = {root_q[SIG_W-2:0], take};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) state_d = S_ROUND;
      end

      S_ROUND: begin
        inv_d = 1'b0;
        inx_d = 1'b0;
        case (cls_q)
          C_ZERO: result_d = {sign_q, {(W-1){1'b0}}};
          C_INF: begin
            result_d = sign_q ? QNAN : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
            inv_d    = sign_q;
          end
          C_QNAN: result_d = QNAN;
          C_SNAN: begin
            result_d = QNAN;
            inv_d    = 1'b1;
          end
          default: begin
            if (sign_q) begin
              result_d = QNAN;
              inv_d    = 1'b1;
            end else begin
              result_d = fin_result;
              inx_d    = guard | sticky;
            end
          end
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cls_q    <= C_ZERO;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cls_q    <= cls_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      inv_q    <= inv_d;
      inx_q    <= inx_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign flag_invalid = inv_q;
  assign flag_inexact = inx_q;

endmodule
